// File: rtl/lpc_sniffer_pkg.sv
// Shared state encoding and constants for the frame serializer.
package lpc_sniffer_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SYNC      = 4'd1,
    SYNC_WAIT = 4'd2,
    FETCH     = 4'd3,
    DATA      = 4'd4,
    DATA_WAIT = 4'd5,
    CSUM      = 4'd6,
    CSUM_WAIT = 4'd7,
    DONE      = 4'd8
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/frame_serializer_if.sv
// Memory-read and UART-transmit signals shared between the serializer and its environment.
interface frame_serializer_if #(
  parameter int AW = 8,
  parameter int SW = 3
);
  logic          read_empty;
  logic [AW-SW-1:0] target_addr;
  logic [SW:0]   frame_len;
  logic [AW-1:0] read_addr;
  logic [7:0]    read_data;
  logic          read_done;
  logic          uart_ready;
  logic [7:0]    uart_data;
  logic          uart_latch;

  modport master (
    input  read_empty, target_addr, frame_len, read_data, uart_ready,
    output read_addr, read_done, uart_data, uart_latch
  );

  modport slave (
    output read_empty, target_addr, frame_len, read_data, uart_ready,
    input  read_addr, read_done, uart_data, uart_latch
  );
endinterface

// File: rtl/frame_serializer_uart_byte_tx_handshake.sv
// Loads one byte into the UART when it is idle and holds the latch until the UART goes busy.
module uart_byte_tx_handshake (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic       hold,
  input  logic [7:0] tx_byte,
  input  logic       uart_ready,
  output logic [7:0] uart_data,
  output logic       uart_latch,
  output logic       loaded,
  output logic       released
);

  assign loaded   = send && uart_ready;
  assign released = hold && !uart_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      uart_data  <= 8'h00;
      uart_latch <= 1'b0;
    end else if (loaded) begin
      uart_data  <= tx_byte;
      uart_latch <= 1'b1;
    end else if (released) begin
      uart_latch <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Reads one frame from a slot of byte memory and sends sync bytes, data and an optional XOR checksum over a UART.
module frame_serializer
  import lpc_sniffer_pkg::*;
#(
  parameter int         AW        = 8,
  parameter int         SW        = 3,
  parameter int         SYNC_LEN  = 2,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
  parameter int         CSUM_EN   = 1
) (
  input  logic                clock,
  input  logic                reset,
  frame_serializer_if.master  bus,
  output logic                busy,
  output logic [15:0]         frame_count
);

  localparam logic [SW:0] SLOT   = {1'b1, {SW{1'b0}}};
  localparam logic [3:0]  SYNC_N = 4'(SYNC_LEN);

  state_t           state, state_next;
  logic [AW-SW-1:0] tgt;
  logic [SW:0]      len, idx;
  logic [3:0]       sync_cnt;
  logic [7:0]       csum;
  logic             send, hold, loaded, released;
  logic [7:0]       tx_byte;

  uart_byte_tx_handshake u_tx (
    .clock      (clock),
    .reset      (reset),
    .send       (send),
    .hold       (hold),
    .tx_byte    (tx_byte),
    .uart_ready (bus.uart_ready),
    .uart_data  (bus.uart_data),
    .uart_latch (bus.uart_latch),
    .loaded     (loaded),
    .released   (released)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!bus.read_empty) state_next = (SYNC_LEN == 0) ? FETCH : SYNC;
      SYNC:      if (loaded) state_next = SYNC_WAIT;
      SYNC_WAIT: if (released) state_next = (sync_cnt + 4'd1 < SYNC_N) ? SYNC : FETCH;
      FETCH: begin
        if (idx == len) state_next = (CSUM_EN != 0) ? CSUM : DONE;
        else            state_next = DATA;
      end
      DATA:      if (loaded) state_next = DATA_WAIT;
      DATA_WAIT: if (released) state_next = FETCH;
      CSUM:      if (loaded) state_next = CSUM_WAIT;
      CSUM_WAIT: if (released) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // One transmitter shared by the three send states; the byte source follows the state.
  always_comb begin
    send    = 1'b0;
    hold    = 1'b0;
    tx_byte = SYNC_BYTE;
    case (state)
      SYNC:                          send = 1'b1;
      DATA:      begin send = 1'b1; tx_byte = bus.read_data; end
      CSUM:      begin send = 1'b1; tx_byte = csum;          end
      SYNC_WAIT, DATA_WAIT, CSUM_WAIT: hold = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tgt         <= '0;
      len         <= '0;
      idx         <= '0;
      sync_cnt    <= 4'd0;
      csum        <= 8'h00;
      frame_count <= 16'd0;
    end else begin
      case (state)
        IDLE: if (!bus.read_empty) begin
          tgt      <= bus.target_addr;
          len      <= (bus.frame_len > SLOT) ? SLOT : bus.frame_len;
          idx      <= '0;
          sync_cnt <= 4'd0;
          csum     <= 8'h00;
        end
        SYNC_WAIT: if (released) sync_cnt <= sync_cnt + 4'd1;
        DATA:      if (loaded)   csum <= csum ^ bus.read_data;
        DATA_WAIT: if (released) idx <= idx + 1'b1;
        DONE:      frame_count <= frame_count + 16'd1;
        default: ;
      endcase
    end
  end

  // The byte index only moves on leaving DATA_WAIT, so the address is stable for each byte's fetch.
  assign bus.read_addr = {tgt, idx[SW-1:0]};
  assign bus.read_done = (state == DONE);
  assign busy          = (state != IDLE);

endmodule
